// File: rtl/text_writer.sv
// Write side of the 80x30 text-mode framebuffer: consumes ASCII bytes, tracks the
// cursor and emits single-cycle text RAM writes, including full-screen and row clears.
module text_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [7:0]  i_char,
  output logic        o_ready,
  output logic        o_we,
  output logic [11:0] o_addr,
  output logic [7:0]  o_data,
  output logic [6:0]  o_col,
  output logic [4:0]  o_row
);

  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0]  COLS_W    = 7'(COLS);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;

  typedef enum logic [1:0] {
    S_CLEAR_ALL = 2'd0,
    S_IDLE      = 2'd1,
    S_CLEAR_ROW = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_cnt;
  logic [6:0]  r_col;
  logic [4:0]  r_row;
  logic        r_we;
  logic [11:0] r_addr;
  logic [7:0]  r_data;

  logic        w_wr;
  logic [11:0] w_waddr;
  logic [7:0]  w_wdata;
  logic [6:0]  w_col_nxt;
  logic        w_adv;
  logic        w_ff;
  logic [6:0]  w_tab;

  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return 12'(row) * 12'(COLS) + 12'(col);
  endfunction

  // Decode of the byte currently offered in IDLE: what to write and where the cursor goes.
  always_comb begin
    w_wr      = 1'b0;
    w_waddr   = cell_addr(r_row, r_col);
    w_wdata   = i_char;
    w_col_nxt = r_col;
    w_adv     = 1'b0;
    w_ff      = 1'b0;
    w_tab     = (r_col | 7'd7) + 7'd1;
    if (i_char >= 8'h20 && i_char <= 8'h7E) begin
      w_wr = 1'b1;
      if (r_col == LAST_COL) begin
        w_col_nxt = 7'd0;
        w_adv     = 1'b1;
      end else begin
        w_col_nxt = r_col + 7'd1;
      end
    end else begin
      case (i_char)
        CH_LF: begin
          w_col_nxt = 7'd0;
          w_adv     = 1'b1;
        end
        CH_CR: w_col_nxt = 7'd0;
        CH_BS: begin
          if (r_col != 7'd0) begin
            w_col_nxt = r_col - 7'd1;
            w_wr      = 1'b1;
            w_wdata   = CLEAR_CHAR;
            w_waddr   = cell_addr(r_row, r_col - 7'd1);
          end
        end
        CH_TAB: begin
          if (w_tab == COLS_W) begin
            w_col_nxt = 7'd0;
            w_adv     = 1'b1;
          end else begin
            w_col_nxt = w_tab;
          end
        end
        CH_FF: begin
          w_col_nxt = 7'd0;
          w_ff      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR_ALL;
      r_cnt   <= 12'd0;
      r_col   <= 7'd0;
      r_row   <= 5'd0;
      r_we    <= 1'b0;
      r_addr  <= 12'd0;
      r_data  <= CLEAR_CHAR;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_CLEAR_ALL: begin
          r_we   <= 1'b1;
          r_addr <= r_cnt;
          r_data <= CLEAR_CHAR;
          if (r_cnt == LAST_CELL) begin
            r_cnt   <= 12'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        S_CLEAR_ROW: begin
          r_we   <= 1'b1;
          r_addr <= cell_addr(r_row, r_cnt[6:0]);
          r_data <= CLEAR_CHAR;
          if (r_cnt[6:0] == LAST_COL) begin
            r_cnt   <= 12'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        S_IDLE: begin
          if (i_valid) begin
            r_we  <= w_wr;
            r_col <= w_col_nxt;
            if (w_wr) begin
              r_addr <= w_waddr;
              r_data <= w_wdata;
            end
            if (w_ff) begin
              r_row   <= 5'd0;
              r_cnt   <= 12'd0;
              r_state <= S_CLEAR_ALL;
            end else if (w_adv) begin
              // Scrolling is not supported: the cursor wraps to the top and row 0 is blanked.
              if (r_row == LAST_ROW) begin
                r_row   <= 5'd0;
                r_cnt   <= 12'd0;
                r_state <= S_CLEAR_ROW;
              end else begin
                r_row <= r_row + 5'd1;
              end
            end
          end
        end
        default: begin
          r_cnt   <= 12'd0;
          r_state <= S_CLEAR_ALL;
        end
      endcase
    end
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_col   = r_col;
  assign o_row   = r_row;

endmodule
